gray_counter: RTL

Parametrised up/down Gray-code counter with synchronous load, selectable wrap or saturate at the range ends, and a registered binary readback. It replaces the fixed-width combinational binary-to-Gray converter as the counting source for the Gray-coded datapaths. Examples are position pointers and sequencers whose outputs cross into other logic and must change one bit per step.

---
 rtl/gray_pkg.sv | 44 ++++
 rtl/gray_counter_gray2bin.sv | 13 +
 rtl/gray_counter.sv | 83 ++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers. Functions work on a fixed maximum width;
// callers zero-extend their operand and truncate the result back to W bits.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Action chosen for one clock edge, in priority order of evaluation.
  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_LOAD,
    STEP_INC,
    STEP_DEC,
    STEP_WRAP_UP,
    STEP_WRAP_DN,
    STEP_SAT
  } step_e;

  function automatic gray_word_t bin2gray(input gray_word_t x);
    return x ^ (x >> 1);
  endfunction

  // Leading zeros from zero-extension leave the low bits of the prefix XOR intact.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned i = 1; i < GRAY_MAX_W; i++) begin
      b[GRAY_MAX_W-1-i] = b[GRAY_MAX_W-i] ^ g[GRAY_MAX_W-1-i];
    end
    return b;
  endfunction

  function automatic gray_word_t max_val(input int unsigned w);
    gray_word_t m;
    m = '0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gray_counter_gray2bin.sv
// Combinational W-bit Gray-to-binary converter for consumers of a Gray count.
module gray2bin
  import gray_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  assign o_bin = W'(gray_pkg::gray2bin(GRAY_MAX_W'(i_gray)));

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with load, wrap or saturate at the ends, and a
// registered binary copy. G is registered from the next binary value, never decoded at the output.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned W    = 4,
  parameter bit          WRAP = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         UP,
  input  logic         LD,
  input  logic [W-1:0] D,
  output logic [W-1:0] G,
  output logic [W-1:0] B,
  output logic         TC,
  output logic         WRAPPED,
  output logic         SAT
);

  localparam logic [W-1:0] C_MAX = W'(max_val(W));

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_gray;
  logic         r_wrapped;
  logic         r_sat;
  logic [W-1:0] w_next_cnt;
  logic [W-1:0] w_next_gray;
  logic         w_at_max;
  logic         w_at_zero;
  step_e        w_step;

  assign w_at_max  = (r_cnt == C_MAX);
  assign w_at_zero = (r_cnt == '0);

  always_comb begin
    w_step = STEP_HOLD;
    if (LD) begin
      w_step = STEP_LOAD;
    end else if (EN && UP) begin
      if (w_at_max) w_step = WRAP ? STEP_WRAP_UP : STEP_SAT;
      else          w_step = STEP_INC;
    end else if (EN) begin
      if (w_at_zero) w_step = WRAP ? STEP_WRAP_DN : STEP_SAT;
      else           w_step = STEP_DEC;
    end
  end

  always_comb begin
    w_next_cnt = r_cnt;
    case (w_step)
      STEP_LOAD:    w_next_cnt = D;
      STEP_INC:     w_next_cnt = r_cnt + W'(1);
      STEP_DEC:     w_next_cnt = r_cnt - W'(1);
      STEP_WRAP_UP: w_next_cnt = '0;
      STEP_WRAP_DN: w_next_cnt = C_MAX;
      default:      w_next_cnt = r_cnt;
    endcase
    w_next_gray = W'(bin2gray(GRAY_MAX_W'(w_next_cnt)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_gray    <= '0;
      r_wrapped <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_cnt     <= w_next_cnt;
      r_gray    <= w_next_gray;
      r_wrapped <= (w_step == STEP_WRAP_UP) || (w_step == STEP_WRAP_DN);
      r_sat     <= (w_step == STEP_SAT);
    end
  end

  assign G       = r_gray;
  assign B       = r_cnt;
  assign WRAPPED = r_wrapped;
  assign SAT     = r_sat;
  assign TC      = UP ? w_at_max : w_at_zero;

endmodule
